// File: rtl/alu_control_word_executor_if.sv
// Bus bundle for the ALU control-word executor: decoder handshake, register file,
// ALU and memory/stack ports. The executor uses the slave modport; its environment uses master.
interface alu_control_word_executor_if;
  logic        cw_valid;
  logic        cw_ready;
  logic [54:0] control_word;
  logic [3:0]  rf_ra;
  logic [3:0]  rf_rb;
  logic [3:0]  rf_rc;
  logic [15:0] rf_da;
  logic [15:0] rf_db;
  logic [15:0] rf_dc;
  logic        alu_start;
  logic [3:0]  alu_op_out;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        mem_req;
  logic        mem_we;
  logic        mem_stk;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        pc_increment;
  logic        busy;
  logic        err;

  modport slave (
    input  cw_valid, control_word, rf_da, rf_db, rf_dc,
           alu_done, alu_result, mem_ack, mem_rdata,
    output cw_ready, rf_ra, rf_rb, rf_rc, alu_start, alu_op_out, alu_a, alu_b,
           mem_req, mem_we, mem_stk, mem_addr, mem_wdata,
           rf_we, rf_waddr, rf_wdata, pc_increment, busy, err
  );

  modport master (
    output cw_valid, control_word, rf_da, rf_db, rf_dc,
           alu_done, alu_result, mem_ack, mem_rdata,
    input  cw_ready, rf_ra, rf_rb, rf_rc, alu_start, alu_op_out, alu_a, alu_b,
           mem_req, mem_we, mem_stk, mem_addr, mem_wdata,
           rf_we, rf_waddr, rf_wdata, pc_increment, busy, err
  );
endinterface

// File: rtl/alu_control_word_executor.sv
// Executes one 55-bit ALU control word: register read, ALU handshake, optional memory/stack
// transaction, writeback and PC increment. Define ALU_EXEC_TIMEOUT_EN to add the EXEC/MEM watchdog.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | ready for a control word
// S_READ   | register-file read, operand and store-data capture
// S_EXEC   | ALU start pulse, then wait for alu_done
// S_MEM    | memory/stack request held until mem_ack
// S_WB     | register writeback strobe
// S_RETIRE | optional PC increment, err pulse for illegal/timed-out words
module alu_control_word_executor #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                        clk,
  input logic                        reset,
  alu_control_word_executor_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_MEM, S_WB, S_RETIRE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [54:0] r_cw;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_st;
  logic [15:0] r_result;
  logic [15:0] r_rdata;
  logic        r_exec_first;
  logic        r_err;
  logic        w_err_set;
  logic        w_accept;
  logic        w_in_illegal;
  logic        w_tmo_hit;
  logic        w_alu_seen;

  logic        w_pc_inc;
  logic [3:0]  w_alu_op;
  logic [15:0] w_a_altern;
  logic [15:0] w_b_altern;
  logic [3:0]  w_a_sel;
  logic [3:0]  w_b_sel;
  logic        w_a_src;
  logic        w_b_src;
  logic [3:0]  w_out_sel;
  logic [1:0]  w_load_src;
  logic        w_store_mem;
  logic        w_store_stk;

  assign {w_pc_inc, w_alu_op, w_a_altern, w_b_altern, w_a_sel, w_b_sel,
          w_a_src, w_b_src, w_out_sel, w_load_src, w_store_mem, w_store_stk} = r_cw;

  assign w_accept     = bus.cw_valid & bus.cw_ready;
  assign w_in_illegal = (bus.control_word[1] & bus.control_word[0]) |
                        ((bus.control_word[1] | bus.control_word[0]) &
                         (bus.control_word[3:2] != 2'b00));
  // The done seen during the start pulse belongs to a previous operation.
  assign w_alu_seen   = bus.alu_done & ~r_exec_first;

`ifdef ALU_EXEC_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tmo_cnt;

  // Down-counter reloads on every state change; terminal count marks the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= TMO_LOAD;
    end else if (w_next != r_state) begin
      r_tmo_cnt <= TMO_LOAD;
    end else if (r_tmo_cnt != '0) begin
      r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == '0);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next    = w_in_illegal ? S_RETIRE : S_READ;
          w_err_set = w_in_illegal;
        end
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: begin
        if (w_alu_seen) begin
          if (w_store_mem | w_store_stk | w_load_src[1]) w_next = S_MEM;
          else if (w_load_src == 2'b01)                  w_next = S_WB;
          else                                           w_next = S_RETIRE;
        end else if (w_tmo_hit) begin
          w_next    = S_RETIRE;
          w_err_set = 1'b1;
        end
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          w_next = (w_load_src != 2'b00) ? S_WB : S_RETIRE;
        end else if (w_tmo_hit) begin
          w_next    = S_RETIRE;
          w_err_set = 1'b1;
        end
      end
      S_WB:     w_next = S_RETIRE;
      S_RETIRE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cw         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_st         <= '0;
      r_result     <= '0;
      r_rdata      <= '0;
      r_exec_first <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_err        <= w_err_set;
      r_exec_first <= (r_state == S_READ);
      if (w_accept) r_cw <= bus.control_word;
      if (r_state == S_READ) begin
        r_a  <= w_a_src ? w_a_altern : bus.rf_da;
        r_b  <= w_b_src ? w_b_altern : bus.rf_db;
        r_st <= bus.rf_dc;
      end
      if ((r_state == S_EXEC) && w_alu_seen) r_result <= bus.alu_result;
      if ((r_state == S_MEM) && bus.mem_ack) r_rdata  <= bus.mem_rdata;
    end
  end

  // Outputs are decoded from state so reset drops every strobe immediately.
  always_comb begin
    bus.cw_ready     = (r_state == S_IDLE) & ~reset;
    bus.busy         = (r_state != S_IDLE);
    bus.err          = r_err;
    bus.rf_ra        = '0;
    bus.rf_rb        = '0;
    bus.rf_rc        = '0;
    bus.alu_start    = 1'b0;
    bus.alu_op_out   = '0;
    bus.alu_a        = '0;
    bus.alu_b        = '0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_stk      = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.rf_we        = 1'b0;
    bus.rf_waddr     = '0;
    bus.rf_wdata     = '0;
    bus.pc_increment = 1'b0;
    case (r_state)
      S_READ: begin
        bus.rf_ra = w_a_sel;
        bus.rf_rb = w_b_sel;
        bus.rf_rc = w_out_sel;
      end
      S_EXEC: begin
        bus.alu_start  = r_exec_first;
        bus.alu_op_out = w_alu_op;
        bus.alu_a      = r_a;
        bus.alu_b      = r_b;
      end
      S_MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = w_store_mem | w_store_stk;
        bus.mem_stk   = w_store_stk | (w_load_src == 2'b11);
        bus.mem_addr  = r_result;
        bus.mem_wdata = r_st;
      end
      S_WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = w_out_sel;
        bus.rf_wdata = (w_load_src == 2'b01) ? r_result : r_rdata;
      end
      S_RETIRE: bus.pc_increment = w_pc_inc;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_word_executor.sv
// Scoreboard bench for alu_control_word_executor: directed control words push expected
// ALU/MEM/WB/ERR/PC events; a negedge monitor pops and compares as the DUT produces them.
module tb_alu_control_word_executor;

`ifdef ALU_EXEC_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  localparam int K_ALU = 0, K_MEM = 1, K_WB = 2, K_ERR = 3, K_PC = 4;

  typedef struct {
    int          kind;
    logic [15:0] f0;
    logic [15:0] f1;
    logic [15:0] f2;
    int          off;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   t_hs = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];

  logic [15:0] regs [16];
  logic [15:0] alu_res;
  int          alu_delay;
  bit          alu_never;
  int          alu_wait;
  logic [15:0] mem_rd;
  int          mem_delay;
  bit          mem_hang;
  bit          force_ack;
  int          mem_wait;
  logic        mreq_prev;
  logic        mreq_prev_r;

  alu_control_word_executor_if ifc ();

  alu_control_word_executor #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ifc.rf_da = regs[ifc.rf_ra];
  assign ifc.rf_db = regs[ifc.rf_rb];
  assign ifc.rf_dc = regs[ifc.rf_rc];

  function automatic logic [54:0] mkcw(input bit pc, input logic [3:0] op,
                                       input logic [15:0] aa, input logic [15:0] bb,
                                       input logic [3:0] as, input logic [3:0] bs,
                                       input bit asrc, input bit bsrc, input logic [3:0] os,
                                       input logic [1:0] ls, input bit sm, input bit ss);
    return {pc, op, aa, bb, as, bs, asrc, bsrc, os, ls, sm, ss};
  endfunction

  task automatic push(input int kind, input logic [15:0] f0, input logic [15:0] f1,
                      input logic [15:0] f2, input int off);
    exp_t e;
    e.kind = kind; e.f0 = f0; e.f1 = f1; e.f2 = f2; e.off = off;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic ev(input int kind, input logic [15:0] f0, input logic [15:0] f1,
                    input logic [15:0] f2);
    exp_t e;
    int   rel;
    n_checks++;
    rel = cyc + 1 - t_hs;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d f0=%h f1=%h f2=%h, expected none (cycle %0d)",
               kind, f0, f1, f2, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.f0 !== f0 || e.f1 !== f1 || e.f2 !== f2 ||
          (e.off >= 0 && e.off != rel)) begin
        n_fail++;
        $display("FAIL event: got kind %0d f0=%h f1=%h f2=%h at T+%0d, expected kind %0d f0=%h f1=%h f2=%h at T+%0d",
                 kind, f0, f1, f2, rel, e.kind, e.f0, e.f1, e.f2, e.off);
      end
    end
  endtask

  // Monitor: compares every DUT-produced event against the scoreboard queue.
  always @(negedge clk) begin
    mreq_prev = mreq_prev_r;
    if (!reset) begin
      if (ifc.alu_start) ev(K_ALU, {12'h0, ifc.alu_op_out}, ifc.alu_a, ifc.alu_b);
      if (ifc.mem_req && !mreq_prev)
        ev(K_MEM, {14'h0, ifc.mem_we, ifc.mem_stk}, ifc.mem_addr, ifc.mem_wdata);
      if (ifc.rf_we) ev(K_WB, {12'h0, ifc.rf_waddr}, ifc.rf_wdata, 16'h0);
      if (ifc.err) ev(K_ERR, 16'h0, 16'h0, 16'h0);
      if (ifc.pc_increment) ev(K_PC, 16'h0, 16'h0, 16'h0);
    end
    mreq_prev_r = ifc.mem_req;
  end

  // ALU responder: done pulse alu_delay cycles after the start pulse.
  always @(negedge clk) begin
    ifc.alu_done = 1'b0;
    if (reset) alu_wait = -1;
    else if (alu_wait == 0) begin
      ifc.alu_done   = 1'b1;
      ifc.alu_result = alu_res;
      alu_wait       = -1;
    end else if (alu_wait > 0) alu_wait--;
    if (!reset && ifc.alu_start && !alu_never) alu_wait = alu_delay - 1;
  end

  // Memory responder: ack pulse mem_delay cycles after the request rises.
  always @(negedge clk) begin
    ifc.mem_ack = 1'b0;
    if (force_ack) begin
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = 16'hDEAD;
      force_ack     = 1'b0;
    end else if (reset) mem_wait = -1;
    else if (mem_wait == 0) begin
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = mem_rd;
      mem_wait      = -1;
    end else if (mem_wait > 0) mem_wait--;
    if (!reset && ifc.mem_req && !mreq_prev && !mem_hang) mem_wait = mem_delay - 1;
  end

  task automatic send(input logic [54:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!ifc.cw_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.cw_ready) chk("send_ready_timeout", {31'h0, ifc.cw_ready}, 32'h1);
    ifc.cw_valid     = 1'b1;
    ifc.control_word = w;
    t_hs             = cyc + 1;
    @(negedge clk);
    ifc.cw_valid     = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || !ifc.cw_ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk({name, "_drain_pending"}, q.size(), 32'h0);
    chk({name, "_drain_idle"}, {31'h0, ifc.cw_ready}, 32'h1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    ifc.cw_valid = 1'b0; ifc.control_word = '0;
    ifc.alu_done = 1'b0; ifc.alu_result = '0;
    ifc.mem_ack = 1'b0;  ifc.mem_rdata = '0;
    alu_res = '0; alu_delay = 1; alu_never = 1'b0; alu_wait = -1;
    mem_rd = '0; mem_delay = 1; mem_hang = 1'b0; force_ack = 1'b0; mem_wait = -1;
    mreq_prev = 1'b0; mreq_prev_r = 1'b0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0100 + 16'(i);

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, ifc.busy}, 32'h0);
    chk("rst_mem_req", {31'h0, ifc.mem_req}, 32'h0);
    chk("rst_rf_we", {31'h0, ifc.rf_we}, 32'h0);
    chk("rst_alu_start", {31'h0, ifc.alu_start}, 32'h0);
    chk("rst_err", {31'h0, ifc.err}, 32'h0);
    chk("rst_pc_inc", {31'h0, ifc.pc_increment}, 32'h0);
    chk("rst_mem_addr", {16'h0, ifc.mem_addr}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cw_ready", {31'h0, ifc.cw_ready}, 32'h1);

    // LDSW: immediate A, writeback of ALU result, exact latency.
    regs[5] = 16'h0007;
    alu_res = 16'h1242; alu_delay = 1;
    push(K_ALU, 16'h0, 16'h1242, 16'h0007, 2);
    push(K_WB, 16'h5, 16'h1242, 16'h0, 4);
    push(K_PC, 16'h0, 16'h0, 16'h0, 5);
    send(mkcw(1, 4'h0, 16'h1242, 16'h0, 4'h0, 4'h5, 1, 0, 4'h5, 2'b01, 0, 0));
    repeat (4) @(negedge clk);
    chk("ldsw_ready_T5", {31'h0, ifc.cw_ready}, 32'h0);
    @(negedge clk);
    chk("ldsw_ready_T6", {31'h0, ifc.cw_ready}, 32'h1);
    drain("ldsw");

    // RMOF: memory load through ALU-computed address.
    regs[0] = 16'h0010; regs[1] = 16'h0004;
    alu_res = 16'h0014; alu_delay = 2;
    mem_rd = 16'hBEEF; mem_delay = 3;
    push(K_ALU, 16'h1, 16'h0010, 16'h0004, -1);
    push(K_MEM, 16'h0, 16'h0014, 16'h0004, -1);
    push(K_WB, 16'h1, 16'hBEEF, 16'h0, -1);
    push(K_PC, 16'h0, 16'h0, 16'h0, -1);
    send(mkcw(1, 4'h1, 16'h0, 16'h0, 4'h0, 4'h1, 0, 0, 4'h1, 2'b10, 0, 0));
    drain("rmof");

    // WSTK: stack store, no writeback.
    regs[0] = 16'h0020;
    alu_res = 16'h0020; alu_delay = 1; mem_delay = 1;
    push(K_ALU, 16'h0, 16'h0020, 16'h0020, -1);
    push(K_MEM, 16'h3, 16'h0020, 16'h0020, -1);
    push(K_PC, 16'h0, 16'h0, 16'h0, -1);
    send(mkcw(1, 4'h0, 16'h0, 16'h0, 4'h0, 4'h0, 0, 0, 4'h0, 2'b00, 0, 1));
    drain("wstk");

    // Illegal: both store bits; err and PC together one cycle after acceptance.
    push(K_ERR, 16'h0, 16'h0, 16'h0, 1);
    push(K_PC, 16'h0, 16'h0, 16'h0, 1);
    send(mkcw(1, 4'h5, 16'h0, 16'h0, 4'h1, 4'h2, 0, 0, 4'h3, 2'b00, 1, 1));
    drain("illegal");

    // Illegal: store with a load source, pc_inc clear.
    push(K_ERR, 16'h0, 16'h0, 16'h0, 1);
    send(mkcw(0, 4'h5, 16'h0, 16'h0, 4'h1, 4'h2, 0, 0, 4'h3, 2'b01, 1, 0));
    drain("illegal_ld");

    // Noop: ALU handshake then retire.
    regs[3] = 16'h0003; regs[4] = 16'h0004;
    alu_res = 16'h0007; alu_delay = 3;
    push(K_ALU, 16'h3, 16'h0003, 16'h0004, 2);
    push(K_PC, 16'h0, 16'h0, 16'h0, -1);
    send(mkcw(1, 4'h3, 16'h0, 16'h0, 4'h3, 4'h4, 0, 0, 4'h0, 2'b00, 0, 0));
    drain("noop");

    // Stack load with immediate B, pc_inc clear.
    regs[2] = 16'h3000; regs[7] = 16'h0077;
    alu_res = 16'h3001; alu_delay = 1;
    mem_rd = 16'h5A5A; mem_delay = 2;
    push(K_ALU, 16'h2, 16'h3000, 16'h00AA, -1);
    push(K_MEM, 16'h1, 16'h3001, 16'h0077, -1);
    push(K_WB, 16'h7, 16'h5A5A, 16'h0, -1);
    send(mkcw(0, 4'h2, 16'h0, 16'h00AA, 4'h2, 4'h0, 0, 1, 4'h7, 2'b11, 0, 0));
    drain("stkld");

`ifdef ALU_EXEC_TIMEOUT_EN
    // Watchdog: ALU never answers; err after four EXEC cycles, no writeback.
    alu_never = 1'b1;
    push(K_ALU, 16'h4, 16'h0003, 16'h0004, 2);
    push(K_ERR, 16'h0, 16'h0, 16'h0, 6);
    push(K_PC, 16'h0, 16'h0, 16'h0, 6);
    send(mkcw(1, 4'h4, 16'h0, 16'h0, 4'h3, 4'h4, 0, 0, 4'h6, 2'b01, 0, 0));
    drain("timeout");
    alu_never = 1'b0;
`endif

    // Reset while MEM is waiting; a late ack must not cause a writeback.
    regs[0] = 16'h0010; regs[1] = 16'h0004;
    alu_res = 16'h0014; alu_delay = 1; mem_hang = 1'b1;
    push(K_ALU, 16'h1, 16'h0010, 16'h0004, -1);
    push(K_MEM, 16'h0, 16'h0014, 16'h0004, -1);
    send(mkcw(1, 4'h1, 16'h0, 16'h0, 4'h0, 4'h1, 0, 0, 4'h1, 2'b10, 0, 0));
    n = 0;
    while (!ifc.mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_mem_req_seen", {31'h0, ifc.mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_mem_req_drop", {31'h0, ifc.mem_req}, 32'h0);
    chk("rstmid_busy", {31'h0, ifc.busy}, 32'h0);
    chk("rstmid_rf_we", {31'h0, ifc.rf_we}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_cw_ready", {31'h0, ifc.cw_ready}, 32'h1);
    mem_hang = 1'b0;
    force_ack = 1'b1;
    repeat (6) @(negedge clk);
    chk("rstmid_busy_after", {31'h0, ifc.busy}, 32'h0);
    drain("rstmid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_word_executor.md
Name: alu_control_word_executor

Overview:
- Consumer end of the 55-bit ALU control word produced by the instruction decoders.
- Accepts one control word per valid/ready handshake and unpacks it in the same field order the control-word encoder uses.
- Sequences one instruction through four steps: register read, multi-cycle ALU handshake, optional memory or stack transaction, then register writeback and program-counter increment.
- Sits between the decoder stage and the register file, ALU and memory/stack arbiter.

Parameters:
- TIMEOUT_CYCLES, 255: watchdog limit, used only with the optional feature.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- cw_valid  in  1  control word present.
- cw_ready  out  1  block can accept; high only in IDLE.
- control_word  in  55  field layout:
  - [54] pc_inc
  - [53:50] alu_op
  - [49:34] a_altern
  - [33:18] b_altern
  - [17:14] a_sel
  - [13:10] b_sel
  - [9] a_src
  - [8] b_src
  - [7:4] out_sel
  - [3:2] load_src
  - [1] store_mem
  - [0] store_stk
- rf_ra, rf_rb, rf_rc  out  4  register-file read addresses (combinational read).
- rf_da, rf_db, rf_dc  in  16  register-file read data.
- alu_start  out  1  one-cycle start pulse.
- alu_op_out  out  4  ALU operation.
- alu_a, alu_b  out  16  ALU operands.
- alu_done  in  1  result valid.
- alu_result  in  16  ALU result.
- mem_req  out  1  transaction request, held until ack.
- mem_we  out  1  write when 1.
- mem_stk  out  1  target stack when 1, memory when 0.
- mem_addr  out  16  address.
- mem_wdata  out  16  store data.
- mem_ack  in  1  completion.
- mem_rdata  in  16  load data, valid with ack.
- rf_we  out  1  writeback strobe.
- rf_waddr  out  4  writeback register.
- rf_wdata  out  16  writeback data.
- pc_increment  out  1  one-cycle pulse at retire.
- busy  out  1  state not IDLE.
- err  out  1  one-cycle pulse on illegal word or timeout.

Behaviour:
- Reset (asynchronous): state IDLE; all strobes 0; all data/address outputs 0; cw_ready=1 once reset deasserts.
- IDLE: on cw_valid&cw_ready, latch the whole word; go to READ.
- Illegal word, checked at acceptance:
  - Illegal when store_mem&store_stk, or when (store_mem|store_stk) with load_src!=00.
  - Response: err pulses in the following cycle; state goes to RETIRE with no ALU, memory or writeback activity.
  - pc_inc is still honoured.
- READ (1 cycle):
  - Drive rf_ra=a_sel, rf_rb=b_sel, rf_rc=out_sel.
  - Register A = a_src ? a_altern : rf_da; B = b_src ? b_altern : rf_db; store data = rf_dc.
  - Go to EXEC.
- EXEC:
  - alu_start pulses in the first EXEC cycle only; alu_op_out/alu_a/alu_b are held stable throughout EXEC.
  - alu_done is ignored in the cycle alu_start is high.
  - On alu_done, latch alu_result (the address for memory ops). Next state:
    - any store bit, or load_src 10/11 → MEM;
    - load_src 01 → WB;
    - load_src 00 → RETIRE.
- MEM:
  - mem_req held high with mem_addr=ALU result.
  - mem_we=store_mem|store_stk.
  - mem_stk=store_stk|(load_src==11).
  - mem_wdata=store data.
  - On mem_ack, drop mem_req the next cycle and latch mem_rdata. Then loads → WB, stores → RETIRE.
  - mem_ack outside MEM is ignored.
- WB (1 cycle):
  - rf_we=1, rf_waddr=out_sel.
  - rf_wdata = ALU result (01) or mem_rdata (10/11).
  - Go to RETIRE.
- RETIRE (1 cycle): pc_increment=pc_inc; go to IDLE.
- Noop word (load_src 00, no stores, pc_inc 1): still performs the ALU handshake, then RETIRE; no rf_we, no mem_req.
- Latency for a load_src=01 word with alu_done one cycle after alu_start:
  - handshake edge T;
  - alu_start at T+2;
  - rf_we at T+4;
  - pc_increment at T+5;
  - cw_ready high again at T+6.
- Reset mid-operation: all strobes drop immediately, the in-flight word is discarded, and no partial writeback occurs.
- Widths: all data 16-bit; no arithmetic is performed in this block.

Optional Feature:
- Macro: ALU_EXEC_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider counter runs in EXEC and MEM.
  - If alu_done or mem_ack is not seen within TIMEOUT_CYCLES cycles, drop alu_start/mem_req and pulse err.
  - Skip WB, go to RETIRE (pc_inc honoured).
  - The counter clears on every state change.
- When undefined: no counter; the block waits indefinitely in EXEC or MEM.

Test Plan:
- LDSW-style word (alu_op=0, a_src=1, a_altern=0x1242, b_sel=5, out_sel=5, load_src=01, pc_inc=1); alu_done one cycle after start with result 0x1242 → alu_a=0x1242; rf_we at T+4 with rf_waddr=5, rf_wdata=0x1242; pc_increment at T+5; no mem_req.
- RMOF word (alu_op=1, a_sel=0, b_sel=1, out_sel=1, load_src=10); rf_da=0x0010, rf_db=0x0004, ALU result 0x0014; mem_ack after 3 cycles with rdata 0xBEEF → mem_addr=0x0014, mem_we=0, mem_stk=0; rf_waddr=1, rf_wdata=0xBEEF.
- WSTK word (alu_op=0, a_sel=0, out_sel=0, store_stk=1); rf_da=0x0020, rf_dc=0x0020 → mem_we=1, mem_stk=1, mem_addr=0x0020, mem_wdata=0x0020; no rf_we; pc_increment pulses.
- Illegal word (store_mem=1, store_stk=1) → err pulse; no alu_start, mem_req or rf_we; pc_increment pulses; cw_ready returns.
- Assert reset while in MEM with mem_req high → mem_req=0 immediately; busy=0, cw_ready=1 after release; later mem_ack causes no writeback.
- With ALU_EXEC_TIMEOUT_EN and TIMEOUT_CYCLES=4, alu_done never asserted → err pulse after 4 EXEC cycles; no rf_we; pc_increment pulses.
